// File: rtl/dm_pkg.sv
// Shared types and constants for the MIPS data memory and its load-extension path.
// Pure declarations and a combinational helper: no latency, no flow control.
package dm_pkg;

  localparam int DATA_W    = 32;
  localparam int HALF_W    = 16;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    LD_WORD   = 2'd0,
    LD_HALF_S = 2'd1,
    LD_HALF_U = 2'd2
  } ld_mode_e;

  // lh wins over lhu when both are asserted.
  function automatic ld_mode_e decode_ld(input logic lh, input logic lhu);
    ld_mode_e mode;
    if (lh) begin
      mode = LD_HALF_S;
    end else if (lhu) begin
      mode = LD_HALF_U;
    end else begin
      mode = LD_WORD;
    end
    return mode;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extends a loaded word to 32 bits per load mode (full word, signed or unsigned halfword).
// Purely combinational, zero latency; no backpressure.
module load_extend
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  ld_mode_e          mode,
  output logic [DATA_W-1:0] result
);

  logic [HALF_W-1:0] half;

  assign half = word[HALF_W-1:0];

  always_comb begin
    result = word;
    case (mode)
      LD_HALF_S: result = {{(DATA_W-HALF_W){half[HALF_W-1]}}, half};
      LD_HALF_U: result = {{(DATA_W-HALF_W){1'b0}}, half};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory: synchronous whole-word stores, combinational loads with halfword extension.
// Store visible after 1 edge, load 0 cycles; always ready, no backpressure.
module data_memory
  import dm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [AW-1:0]     address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              lh,
  input  logic              lhu
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ext_word;
  ld_mode_e          ld_mode;
  logic              unused_addr_hi;

  // Upper address bits are ignored so out-of-range addresses wrap modulo DEPTH.
  assign idx            = address[IW-1:0];
  assign unused_addr_hi = ^address[AW-1:IW];

  assign rd_word = mem[idx];
  assign ld_mode = decode_ld(lh, lhu);

  load_extend u_load_extend (
    .word   (rd_word),
    .mode   (ld_mode),
    .result (ext_word)
  );

  // An X on MemWrite takes the else path, so it never commits a store.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem <= '{default: '0};
    end else if (MemWrite) begin
      mem[idx] <= data_in;
    end
  end

  always_comb begin
    data_out = '0;
    if (MemRead) begin
      data_out = ext_word;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: stores, halfword loads, gating, RDW, reset, wrap.
// Expected values are hand-computed constants.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic          Clk;
  logic          Reset_n;
  logic [31:0]   data_out;
  logic [31:0]   data_in;
  logic [AW-1:0] address;
  logic          MemRead;
  logic          MemWrite;
  logic          lh;
  logic          lhu;

  int checks;
  int failures;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .data_out (data_out),
    .data_in  (data_in),
    .address  (address),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .lh       (lh),
    .lhu      (lhu)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (data_out === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, data_out, exp);
    end
  endtask

  // Store occurs on the posedge between two negedges.
  task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge Clk);
    address  = a;
    data_in  = d;
    MemWrite = 1'b1;
    @(negedge Clk);
    MemWrite = 1'b0;
  endtask

  // Combinational load sampled 1 time unit after the inputs settle, mid-cycle.
  task automatic load(input string tag, input logic [AW-1:0] a, input logic rd,
                      input logic s, input logic u, input logic [31:0] exp);
    address = a;
    MemRead = rd;
    lh      = s;
    lhu     = u;
    #1;
    check(tag, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    data_in  = '0;
    address  = '0;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    lh       = 1'b0;
    lhu      = 1'b0;

    #2;
    check("reset_word0", 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    store(50, 32'd1200);
    store(60, 32'd5400);
    store(40, 32'd131071);

    @(negedge Clk);
    load("word_50", 50, 1'b1, 1'b0, 1'b0, 32'd1200);
    load("word_60", 60, 1'b1, 1'b0, 1'b0, 32'd5400);
    load("word_40", 40, 1'b1, 1'b0, 1'b0, 32'd131071);

    load("lh_40", 40, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    load("lhu_40", 40, 1'b1, 1'b0, 1'b1, 32'h0000_FFFF);
    load("lh_lhu_40", 40, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);

    @(negedge Clk);
    load("gate_lh", 40, 1'b0, 1'b1, 1'b0, 32'h0);
    load("gate_lhu_60", 60, 1'b0, 1'b0, 1'b1, 32'h0);
    load("gate_raise", 60, 1'b1, 1'b0, 1'b0, 32'd5400);

    store(40, 32'h1234_7FFF);
    load("lh_pos_40", 40, 1'b1, 1'b1, 1'b0, 32'h0000_7FFF);
    lh = 1'b0;

    // Read-during-write: old word until the edge, new word after.
    store(10, 32'd7);
    @(negedge Clk);
    address  = 10;
    MemRead  = 1'b1;
    data_in  = 32'd9;
    MemWrite = 1'b1;
    #1;
    check("rdw_before", 32'd7);
    @(posedge Clk);
    #1;
    check("rdw_after", 32'd9);
    @(negedge Clk);
    MemWrite = 1'b0;

    store(DEPTH + 3, 32'hDEAD_BEEF);
    load("wrap_3", 3, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    load("wrap_alias", DEPTH + 3, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Mid-cycle reset assertion, no clock edge involved.
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    load("rst_50", 50, 1'b1, 1'b0, 1'b0, 32'h0);
    load("rst_60", 60, 1'b1, 1'b0, 1'b0, 32'h0);
    load("rst_40", 40, 1'b1, 1'b0, 1'b0, 32'h0);

    address  = 50;
    data_in  = 32'hAAAA_AAAA;
    MemWrite = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    MemWrite = 1'b0;
    #1;
    Reset_n = 1'b1;
    load("rst_store_lost", 50, 1'b1, 1'b0, 1'b0, 32'h0);

    store(5, 32'h0000_0055);
    load("post_rst_store", 5, 1'b1, 1'b0, 1'b0, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
